// File: rtl/fpalu_sequencer_if.sv
// Issue/result bundle between the main control unit, the sequencer and the FP ALU.
interface fpalu_sequencer_if;
  logic        iStart;
  logic [3:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iFlush;
  logic [31:0] iALUResult;
  logic [3:0]  oALUOp;
  logic [31:0] oALUA;
  logic [31:0] oALUB;
  logic [31:0] oResult;
  logic        oCondFlag;
  logic        oBusy;
  logic        oDone;
  logic        oIllegal;

  // Control unit / FP ALU side.
  modport master (
    output iStart, iOp, iA, iB, iFlush, iALUResult,
    input  oALUOp, oALUA, oALUB, oResult, oCondFlag, oBusy, oDone, oIllegal
  );

  // Sequencer side.
  modport slave (
    input  iStart, iOp, iA, iB, iFlush, iALUResult,
    output oALUOp, oALUA, oALUB, oResult, oCondFlag, oBusy, oDone, oIllegal
  );
endinterface

// File: rtl/fpalu_sequencer.sv
// Multicycle sequencer for the FP ALU: latches op/operands, holds them for the
// op latency, captures the result or compare flag, then pulses done.
module fpalu_sequencer #(
  parameter int unsigned LAT_ADD    = 4,
  parameter int unsigned LAT_MUL    = 5,
  parameter int unsigned LAT_DIV    = 12,
  parameter int unsigned LAT_SQRT   = 16,
  parameter int unsigned LAT_CVT    = 3,
  parameter int unsigned LAT_SIMPLE = 1
) (
  input logic               iCLK,
  input logic               iRST,
  fpalu_sequencer_if.slave  bus
);

  localparam logic [3:0] OpAdd   = 4'h1;
  localparam logic [3:0] OpSub   = 4'h2;
  localparam logic [3:0] OpMul   = 4'h3;
  localparam logic [3:0] OpDiv   = 4'h4;
  localparam logic [3:0] OpSqrt  = 4'h5;
  localparam logic [3:0] OpAbs   = 4'h6;
  localparam logic [3:0] OpNeg   = 4'h7;
  localparam logic [3:0] OpCeq   = 4'h8;
  localparam logic [3:0] OpClt   = 4'h9;
  localparam logic [3:0] OpCle   = 4'hA;
  localparam logic [3:0] OpCvtsw = 4'hB;
  localparam logic [3:0] OpCvtws = 4'hC;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Counter preload is latency-1; a latency of 0 behaves like 1.
  function automatic logic [4:0] lat_m1(input int unsigned lat);
    if (lat <= 1) return 5'd0;
    return 5'(lat - 1);
  endfunction

  localparam logic [4:0] CntAdd    = lat_m1(LAT_ADD);
  localparam logic [4:0] CntMul    = lat_m1(LAT_MUL);
  localparam logic [4:0] CntDiv    = lat_m1(LAT_DIV);
  localparam logic [4:0] CntSqrt   = lat_m1(LAT_SQRT);
  localparam logic [4:0] CntCvt    = lat_m1(LAT_CVT);
  localparam logic [4:0] CntSimple = lat_m1(LAT_SIMPLE);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;
  logic        cond_q;
  logic        busy_q;
  logic        done_q;
  logic        illegal_q;

  logic        start_legal;
  logic [4:0]  start_cnt;
  logic        run_is_cmp;

  // Decode the incoming op: legality and counter preload.
  always_comb begin
    start_legal = 1'b1;
    start_cnt   = 5'd0;
    unique case (bus.iOp)
      OpAdd, OpSub:                       start_cnt = CntAdd;
      OpMul:                              start_cnt = CntMul;
      OpDiv:                              start_cnt = CntDiv;
      OpSqrt:                             start_cnt = CntSqrt;
      OpCvtsw, OpCvtws:                   start_cnt = CntCvt;
      OpAbs, OpNeg, OpCeq, OpClt, OpCle:  start_cnt = CntSimple;
      default:                            start_legal = 1'b0;
    endcase
  end

  // Compares update only the condition flag, never the result register.
  always_comb begin
    run_is_cmp = (op_q == OpCeq) || (op_q == OpClt) || (op_q == OpCle);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      op_q      <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      result_q  <= 32'd0;
      cond_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (bus.iFlush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
          end else begin
            if (run_is_cmp) cond_q <= bus.iALUResult[0];
            else            result_q <= bus.iALUResult;
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a start; flush blocks it and returns to IDLE.
          if (bus.iFlush || !bus.iStart) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (start_legal) begin
            op_q    <= bus.iOp;
            a_q     <= bus.iA;
            b_q     <= bus.iB;
            cnt_q   <= start_cnt;
            state_q <= StRun;
            busy_q  <= 1'b1;
          end else begin
            state_q   <= StDone;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.oALUOp    = op_q;
  assign bus.oALUA     = a_q;
  assign bus.oALUB     = b_q;
  assign bus.oResult   = result_q;
  assign bus.oCondFlag = cond_q;
  assign bus.oBusy     = busy_q;
  assign bus.oDone     = done_q;
  assign bus.oIllegal  = illegal_q;

endmodule

// File: tb/tb_fpalu_sequencer.sv
// Directed bench for fpalu_sequencer with a scoreboard of expected completions.
module tb_fpalu_sequencer;

  logic iCLK;
  logic iRST;

  fpalu_sequencer_if bus ();

  fpalu_sequencer dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        cond;
    logic        ill;
    logic [3:0]  op;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] m_res  = '0;
  logic        m_cond = 1'b0;
  logic [3:0]  m_op   = '0;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " op"},   32'(bus.oALUOp), 32'd0);
    check({tag, " a"},    bus.oALUA, 32'd0);
    check({tag, " b"},    bus.oALUB, 32'd0);
    check({tag, " res"},  bus.oResult, 32'd0);
    check({tag, " cond"}, 32'(bus.oCondFlag), 32'd0);
    check({tag, " busy"}, 32'(bus.oBusy), 32'd0);
    check({tag, " done"}, 32'(bus.oDone), 32'd0);
    check({tag, " ill"},  32'(bus.oIllegal), 32'd0);
  endtask

  // Drive a start for one edge; push the expected completion when one is due.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] alu, input bit push);
    exp_t e;
    bit   legal;
    bit   cmp;
    legal = (op >= 4'd1) && (op <= 4'd12);
    cmp   = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
    if (legal) m_op = op;
    if (legal && push) begin
      if (cmp) m_cond = alu[0];
      else     m_res  = alu;
    end
    e = '{res: m_res, cond: m_cond, ill: !legal, op: m_op};
    if (push) sb.push_back(e);
    bus.iOp        = op;
    bus.iA         = a;
    bus.iB         = b;
    bus.iALUResult = alu;
    bus.iStart     = 1'b1;
    tick();
    bus.iStart = 1'b0;
  endtask

  // Wait (bounded) for oDone, check timing, then pop and compare the scoreboard.
  task automatic wait_done(input string tag, input int exp_n, input int exp_busy);
    int   n    = 0;
    int   busy = 0;
    exp_t e;
    while (bus.oDone !== 1'b1 && n < 64) begin
      if (bus.oBusy === 1'b1) busy++;
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_n));
    check({tag, " busy cycles"}, 32'(busy), 32'(exp_busy));
    check({tag, " pending"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " result"}, bus.oResult, e.res);
      check({tag, " cond"}, 32'(bus.oCondFlag), 32'(e.cond));
      check({tag, " illegal"}, 32'(bus.oIllegal), 32'(e.ill));
      check({tag, " aluop"}, 32'(bus.oALUOp), 32'(e.op));
    end
  endtask

  initial begin
    int ndone;
    iRST           = 1'b1;
    bus.iStart     = 1'b0;
    bus.iOp        = '0;
    bus.iA         = '0;
    bus.iB         = '0;
    bus.iFlush     = 1'b0;
    bus.iALUResult = '0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    check_zero("reset");
    tick();

    // ADD: 4-cycle latency, result captured, flag untouched.
    issue(4'h1, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    check("add operand a", bus.oALUA, 32'h3F800000);
    check("add operand b", bus.oALUB, 32'h40000000);
    wait_done("add", 4, 4);
    tick();
    check("add done one-shot", 32'(bus.oDone), 32'd0);

    // Compares: flag only.
    issue(4'h9, 32'h3F800000, 32'h40000000, 32'hFFFF0001, 1'b1);
    wait_done("clt", 1, 1);
    issue(4'h8, 32'h3F800000, 32'h40000000, 32'h12345670, 1'b1);
    wait_done("ceq", 1, 1);

    // Illegal op: immediate done with illegal, nothing latched.
    tick();
    issue(4'hF, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000001, 1'b1);
    check("illegal operand a kept", bus.oALUA, 32'h3F800000);
    wait_done("illegal", 0, 0);
    tick();
    check("illegal clears", 32'(bus.oIllegal), 32'd0);

    // DIV with a second start during RUN that must be ignored.
    issue(4'h4, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
    tick();
    bus.iOp    = 4'h1;
    bus.iA     = 32'h11111111;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check("div operand held", bus.oALUA, 32'h40C00000);
    wait_done("div", 10, 10);
    tick();
    check("div no second done", 32'(bus.oDone), 32'd0);
    check("div idle after", 32'(bus.oBusy), 32'd0);

    // SQRT flushed mid-flight: no capture, no done.
    issue(4'h5, 32'h41100000, 32'h0, 32'h77777777, 1'b0);
    repeat (6) tick();
    bus.iFlush = 1'b1;
    tick();
    bus.iFlush = 1'b0;
    check("flush busy", 32'(bus.oBusy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.oDone === 1'b1) ndone++;
      tick();
    end
    check("flush no done", 32'(ndone), 32'd0);
    check("flush result kept", bus.oResult, m_res);
    issue(4'h1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b1);
    wait_done("add after flush", 4, 4);

    // Asynchronous reset in the middle of a MUL.
    tick();
    issue(4'h3, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    tick();
    #2;
    iRST = 1'b1;
    #1;
    check_zero("async reset");
    @(negedge iCLK);
    iRST   = 1'b0;
    m_res  = '0;
    m_cond = 1'b0;
    m_op   = '0;

    // Back-to-back NEG then ABS, second start issued in DONE.
    issue(4'h7, 32'h3F800000, 32'h0, 32'hBF800000, 1'b1);
    wait_done("neg", 1, 1);
    issue(4'h6, 32'hBF800000, 32'h0, 32'h3F800000, 1'b1);
    wait_done("abs", 1, 1);
    check("abs operand a", bus.oALUA, 32'hBF800000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
